// File: rtl/simpletest_alu_pipe.sv
// -----------------------------------------------------------------------------
// simpletest_alu_pipe
//
// Two-stage pipelined arithmetic test block. Operand pairs enter over a
// valid/ready handshake. Each transaction selects one of four unsigned
// operations. A WIDTH-bit result and zero/carry flags come out one register
// stage after the operands are captured. Completed output handshakes are
// counted in a saturating 16-bit counter.
//
// Optional feature (macro SIMPLETEST_KEY_LOCK_EN):
//   When defined, the key is captured with the operands. If the captured key
//   differs from KEY_VALUE, the delivered result is the true result XOR a
//   mask, and carry is forced to 0. The mask is (key ^ KEY_VALUE), repeated
//   and truncated to WIDTH bits.
//   When undefined, the key is not stored, the result is always the true
//   result, and the key port is present but ignored.
//
// Parameters:
//   WIDTH      operand/result width (must be >= KEY_W)
//   KEY_W      key width
//   KEY_VALUE  correct unlock key
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   in_valid_i   operand pair valid
//   in_ready_o   block can accept operands this cycle
//   sel_i        operation: 00 add, 01 sub, 10 mul, 11 unsigned max
//   in1_i        operand A
//   in2_i        operand B
//   key_i        unlock key, sampled together with the operands
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   out_o        result
//   zero_o       result equals zero (evaluated on the delivered value)
//   carry_o      add carry-out / sub borrow / mul high half nonzero / 0 for max
//   op_count_o   completed output handshakes, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module simpletest_alu_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               KEY_W     = 8,
    parameter logic [KEY_W-1:0] KEY_VALUE = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic [15:0]      op_count_o
);

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;
    localparam logic [1:0] SEL_MUL = 2'b10;
    localparam logic [1:0] SEL_MAX = 2'b11;

    // ------------------------------------------------------------------
    // Global pipeline enable. The whole pipe freezes only when a result is
    // waiting and the sink is not taking it. Stage 1 therefore always
    // advances into stage 2 when stage 2 drains in the same cycle. This is
    // why a simultaneous output and input handshake create no bubble.
    // ------------------------------------------------------------------
    logic en;

    assign en         = !(out_valid_o && !out_ready_i);
    assign in_ready_o = en;

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    logic             s1_valid_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic [1:0]       sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            sel_q      <= SEL_ADD;
        end else if (en) begin
            s1_valid_q <= in_valid_i;
            op1_q      <= in1_i;
            op2_q      <= in2_i;
            sel_q      <= sel_i;
        end
    end

`ifdef SIMPLETEST_KEY_LOCK_EN
    logic [KEY_W-1:0] key_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= '0;
        end else if (en) begin
            key_q <= key_i;
        end
    end
`else
    // The key port stays on the interface so both builds share one pinout.
    // Its value is deliberately discarded.
    logic unused_key;

    assign unused_key = ^{key_i, KEY_VALUE};
`endif

    // ------------------------------------------------------------------
    // Stage 2 combinational: true arithmetic result
    // ------------------------------------------------------------------
    logic [WIDTH:0]     sum_w;
    logic [2*WIDTH-1:0] prod_w;
    logic [WIDTH-1:0]   res_true;
    logic               carry_true;

    always_comb begin
        sum_w      = {1'b0, op1_q} + {1'b0, op2_q};
        prod_w     = {{WIDTH{1'b0}}, op1_q} * {{WIDTH{1'b0}}, op2_q};
        res_true   = '0;
        carry_true = 1'b0;
        unique case (sel_q)
            SEL_ADD: begin
                res_true   = sum_w[WIDTH-1:0];
                carry_true = sum_w[WIDTH];
            end
            SEL_SUB: begin
                res_true   = op1_q - op2_q;
                carry_true = (op1_q < op2_q);
            end
            SEL_MUL: begin
                res_true   = prod_w[WIDTH-1:0];
                carry_true = |prod_w[2*WIDTH-1:WIDTH];
            end
            SEL_MAX: begin
                res_true   = (op1_q >= op2_q) ? op1_q : op2_q;
                carry_true = 1'b0;
            end
            default: begin
                res_true   = '0;
                carry_true = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: optional output locking
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_d;
    logic             carry_d;
    logic             zero_d;

`ifdef SIMPLETEST_KEY_LOCK_EN
    logic [KEY_W-1:0] key_diff;
    logic [WIDTH-1:0] lock_mask;
    logic             locked;

    assign key_diff = key_q ^ KEY_VALUE;
    assign locked   = (key_q != KEY_VALUE);

    // Key difference repeated across the result width. Any high bits that do
    // not fill a whole repetition are taken from the low bits of the key.
    for (genvar g = 0; g < WIDTH; g++) begin : g_mask
        assign lock_mask[g] = key_diff[g % KEY_W];
    end

    always_comb begin
        out_d   = res_true;
        carry_d = carry_true;
        if (locked) begin
            out_d   = res_true ^ lock_mask;
            carry_d = 1'b0;
        end
    end
`else
    always_comb begin
        out_d   = res_true;
        carry_d = carry_true;
    end
`endif

    // The zero flag describes the value actually delivered, after any lock mask.
    assign zero_d = (out_d == '0);

    // ------------------------------------------------------------------
    // Stage 2 registers. The data registers load on every enabled cycle,
    // including bubbles. Only out_valid_q gives the data meaning.
    // ------------------------------------------------------------------
    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;
    logic             carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else if (en) begin
            out_valid_q <= s1_valid_q;
            out_q       <= out_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
        end
    end

    // ------------------------------------------------------------------
    // Completed-transaction counter, saturating
    // ------------------------------------------------------------------
    logic [15:0] op_count_q;
    logic [15:0] op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (out_valid_q && out_ready_i && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_o       = out_q;
    assign zero_o      = zero_q;
    assign carry_o     = carry_q;
    assign op_count_o  = op_count_q;

endmodule

// File: tb/tb_simpletest_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_simpletest_alu_pipe
//
// Directed bench for simpletest_alu_pipe at the default parameters
// (WIDTH=8, KEY_W=8, KEY_VALUE=8'hA5). A table of vectors streams back to
// back. The table holds expected values for the unlocked build and for the
// SIMPLETEST_KEY_LOCK_EN build. Hand-written sequences cover backpressure,
// per-transaction keys and asynchronous reset in the middle of traffic.
// -----------------------------------------------------------------------------
module tb_simpletest_alu_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  sel_i;
    logic [7:0]  in1_i;
    logic [7:0]  in2_i;
    logic [7:0]  key_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_o;
    logic        zero_o;
    logic        carry_o;
    logic [15:0] op_count_o;

    int checks;
    int errors;

    simpletest_alu_pipe #(
        .WIDTH    (8),
        .KEY_W    (8),
        .KEY_VALUE(8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .sel_i      (sel_i),
        .in1_i      (in1_i),
        .in2_i      (in2_i),
        .key_i      (key_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_o      (out_o),
        .zero_o     (zero_o),
        .carry_o    (carry_o),
        .op_count_o (op_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] key;
        logic [7:0] exp_out;     // unlocked build
        logic       exp_carry;
        logic       exp_zero;
        logic [7:0] exp_out_lk;  // SIMPLETEST_KEY_LOCK_EN build
        logic       exp_carry_lk;
        logic       exp_zero_lk;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] k);
        in_valid_i = v;
        sel_i      = s;
        in1_i      = a;
        in2_i      = b;
        key_i      = k;
    endtask

    task automatic check_result(input string name, input vec_t v);
`ifdef SIMPLETEST_KEY_LOCK_EN
        check({name, "_out"},   {24'd0, out_o},   {24'd0, v.exp_out_lk});
        check({name, "_carry"}, {31'd0, carry_o}, {31'd0, v.exp_carry_lk});
        check({name, "_zero"},  {31'd0, zero_o},  {31'd0, v.exp_zero_lk});
`else
        check({name, "_out"},   {24'd0, out_o},   {24'd0, v.exp_out});
        check({name, "_carry"}, {31'd0, carry_o}, {31'd0, v.exp_carry});
        check({name, "_zero"},  {31'd0, zero_o},  {31'd0, v.exp_zero});
`endif
    endtask

    int         exp_cnt;
    int         src_idx;
    logic [7:0] bp_src[3];
    logic [7:0] bp_exp[3];
    logic [7:0] got[$];
    vec_t       kv;

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;

        //         sel    a      b      key    out    c     z     out_lk c_lk  z_lk
        vecs[0]  = '{2'b00, 8'hF0, 8'h20, 8'hA5, 8'h10, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0};
        vecs[1]  = '{2'b01, 8'h05, 8'h05, 8'hA5, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{2'b01, 8'h03, 8'h05, 8'hA5, 8'hFE, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[3]  = '{2'b10, 8'h10, 8'h10, 8'hA5, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[4]  = '{2'b11, 8'h7F, 8'h80, 8'hA5, 8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[5]  = '{2'b00, 8'h01, 8'h01, 8'h00, 8'h02, 1'b0, 1'b0, 8'hA7, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 8'h0F, 8'h11, 8'hA5, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 8'h80, 8'h7F, 8'hA5, 8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 8'hFF, 8'h01, 8'hA5, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[9]  = '{2'b01, 8'h00, 8'h01, 8'hA5, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[10] = '{2'b01, 8'h10, 8'h10, 8'h5A, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 8'hFF, 8'hFF, 8'hA5, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};

        // ---------------- reset values ----------------
        rst         = 1'b1;
        out_ready_i = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 8'hA5);
        #12;
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_out",       {24'd0, out_o},       32'd0);
        check("rst_zero",      {31'd0, zero_o},      32'd0);
        check("rst_carry",     {31'd0, carry_o},     32'd0);
        check("rst_op_count",  {16'd0, op_count_o},  32'd0);
        check("rst_in_ready",  {31'd0, in_ready_o},  32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("post_rst_valid",    {31'd0, out_valid_o}, 32'd0);

        // ---------------- table stream, back to back ----------------
        for (int i = 0; i <= NVEC; i++) begin
            @(negedge clk);
            if (i < NVEC) drive(1'b1, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].key);
            else          drive(1'b0, 2'b00, 8'h00, 8'h00, 8'hA5);
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready_o}, 32'd1);
            @(posedge clk);
            #1;
            if (i >= 1) begin
                check($sformatf("v%0d_valid", i - 1), {31'd0, out_valid_o}, 32'd1);
                check_result($sformatf("v%0d", i - 1), vecs[i - 1]);
            end
        end
        exp_cnt += NVEC;
        @(posedge clk);
        #1;
        check("stream_drain_valid", {31'd0, out_valid_o}, 32'd0);
        check("stream_op_count",    {16'd0, op_count_o},  exp_cnt);

        // ---------------- backpressure ----------------
        bp_src[0] = 8'h01; bp_src[1] = 8'h02; bp_src[2] = 8'h03;
        bp_exp[0] = 8'h02; bp_exp[1] = 8'h04; bp_exp[2] = 8'h06;
        src_idx = 0;
        got.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready_i = (c >= 5);
            if (src_idx < 3) drive(1'b1, 2'b00, bp_src[src_idx], bp_src[src_idx], 8'hA5);
            else             drive(1'b0, 2'b00, 8'h00, 8'h00, 8'hA5);
            #1;
            if (c == 3) begin
                check("bp_stall_in_ready", {31'd0, in_ready_o},  32'd0);
                check("bp_stall_valid",    {31'd0, out_valid_o}, 32'd1);
                check("bp_stall_out",      {24'd0, out_o},       32'h02);
            end
            if (c == 4) check("bp_stall_taken", src_idx, 2);
            if (out_valid_o && out_ready_i) got.push_back(out_o);
            if (in_valid_i && in_ready_o) src_idx++;
            @(posedge clk);
        end
        exp_cnt += 3;
        check("bp_src_taken", src_idx, 3);
        check("bp_got_count", got.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) check($sformatf("bp_got%0d", k), {24'd0, got[k]}, {24'd0, bp_exp[k]});
        end
        #1;
        check("bp_op_count", {16'd0, op_count_o}, exp_cnt);

        // ---------------- per-transaction key ----------------
        out_ready_i = 1'b1;
        @(negedge clk);
        drive(1'b1, 2'b00, 8'h01, 8'h01, 8'h00);
        @(negedge clk);
        drive(1'b1, 2'b00, 8'h01, 8'h01, 8'hA5);
        @(posedge clk);
        #1;
        kv = vecs[5];
        check_result("key_bad", kv);
        @(negedge clk);
        drive(1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        kv = '{2'b00, 8'h01, 8'h01, 8'hA5, 8'h02, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        check_result("key_good", kv);
        @(posedge clk);
        #1;
        exp_cnt += 2;
        check("key_op_count", {16'd0, op_count_o}, exp_cnt);

        // ---------------- asynchronous reset mid-operation ----------------
        @(negedge clk);
        out_ready_i = 1'b0;
        drive(1'b1, 2'b00, 8'h07, 8'h07, 8'hA5);
        @(negedge clk);
        drive(1'b1, 2'b00, 8'h08, 8'h08, 8'hA5);
        @(negedge clk);
        check("mid_pre_valid", {31'd0, out_valid_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid",    {31'd0, out_valid_o}, 32'd0);
        check("mid_rst_out",      {24'd0, out_o},       32'd0);
        check("mid_rst_op_count", {16'd0, op_count_o},  32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready_o},  32'd1);
        drive(1'b0, 2'b00, 8'h00, 8'h00, 8'hA5);
        out_ready_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("mid_drop_valid%0d", c), {31'd0, out_valid_o}, 32'd0);
        end
        check("mid_drop_op_count", {16'd0, op_count_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simpletest_alu_pipe.md
# simpletest_alu_pipe

Parametrised, pipelined successor to the single-cycle key-gated arithmetic test block. It accepts operand pairs over a valid/ready handshake and computes one of four operations selected per transaction. It delivers a WIDTH-bit result plus zero/carry flags two cycles later and counts completed transactions. Key-based output locking is optional and sits in the last stage. The block is a dataflow-graph extraction test vehicle in the simple_test suite.

## Interface
- WIDTH, 8, operand/result width (≥ KEY_W)
- KEY_W, 8, key width
- KEY_VALUE, 8'hA5, correct unlock key (KEY_W bits)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands this cycle
- sel  input  2  operation: 00 add, 01 sub, 10 mul, 11 unsigned max
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- key  input  KEY_W  unlock key, sampled with operands
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out  output  WIDTH  result
- zero  output  1  out == 0
- carry  output  1  add carry-out / sub borrow / mul high half nonzero / 0 for max
- op_count  output  16  completed output handshakes, saturating

## Operation
- Global enable en = !(out_valid && !out_ready); in_ready = en.
- Stage 1 (when en): s1_valid <= in_valid; op1, op2, sel_r, key_r <= in1, in2, sel, key. Holds when !en.
- Stage 2 (when en): out_valid <= s1_valid; out, zero, carry <= f(op1, op2, sel_r, key_r). Holds when !en.
- Arithmetic, unsigned, full result computed at WIDTH+1 (add/sub) or 2·WIDTH (mul):
  - add: out = low WIDTH of op1+op2; carry = bit WIDTH.
  - sub: out = op1−op2 mod 2^WIDTH; carry = (op1 < op2).
  - mul: out = low WIDTH of product; carry = |high WIDTH.
  - max: out = (op1 ≥ op2) ? op1 : op2; carry = 0.
- Locking applies when key_r != KEY_VALUE: out = true result XOR mask, where mask = (key_r ^ KEY_VALUE) replicated and truncated to WIDTH; carry forced 0; zero computed from the delivered out.
- op_count increments on (out_valid && out_ready) and saturates at 16'hFFFF.
- Bubbles (s1_valid=0) pass through. Stage-2 data registers load on every en regardless of s1_valid.

## Timing
- Reset values: out_valid=0, out=0, zero=0, carry=0, op_count=0, s1_valid=0. in_ready=1 in reset and the cycle after.
- Latency: operands accepted at edge N → out_valid=1 after edge N+1. Throughput is 1/cycle with out_ready=1.
- Maximum in flight is 2 (s1 and output). Under stall both stages hold, in_ready=0, and out/flags stay stable until accepted.
- A simultaneous output handshake and new input in the same cycle are both taken, with no bubble.
- An input offered while in_ready=0 is not taken. The source must hold it.
- Reset asserted mid-operation clears all state immediately (asynchronous). In-flight results are dropped and op_count returns to 0.
- The key is per-transaction: changing key affects only transactions accepted afterward.

## Configuration
- SIMPLETEST_KEY_LOCK_EN defined: locking as above. key and KEY_VALUE are used.
- Not defined: key_r is not stored, out/carry are always the true result, and the key port is present but ignored.

## Test plan
- Reset: assert rst mid-stream → out_valid=0, out=0, op_count=0 immediately. After release, in_ready=1.
- Add: sel=00, in1=8'hF0, in2=8'h20, key=8'hA5 at edge N → after edge N+1 out=8'h10, carry=1, zero=0. After handshake, op_count=1.
- Sub/zero: 8'h05−8'h05 → out=8'h00, zero=1, carry=0. Then 8'h03−8'h05 back-to-back → out=8'hFE, carry=1 on the next cycle.
- Mul/max: 8'h10×8'h10 → out=8'h00, zero=1, carry=1. Max(8'h7F, 8'h80) → 8'h80, carry=0.
- Backpressure: out_ready=0 while three adds (1+1, 2+2, 3+3) are offered → first two accepted, in_ready=0, out held at 8'h02. Raising out_ready yields 02, 04, 06 in order with no loss or duplication; op_count=3.
- Wrong key: add 1+1, key=8'h00 → out=8'hA7, carry=0 with SIMPLETEST_KEY_LOCK_EN; out=8'h02 without it.
